// File: rtl/scg_pkg.sv
// Shared definitions for the scg_* SDRAM command sequencers: command codes,
// the write-AP burst state encoding and small sizing helpers.
package scg_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP    = 4'd0;
  localparam cmd_t CMD_WRITEA = 4'd5;

  typedef enum logic [2:0] {
    WAP_IDLE,
    WAP_WRITE,
    WAP_BURST,
    WAP_RECOVER,
    WAP_PRECHG,
    WAP_DONE
  } wap_state_e;

  function automatic int scg_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Beat index width; never below 1 so a single-beat build still has a port.
  function automatic int scg_beat_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/scg_writeap_burst_if.sv
// Controller <-> write-AP burst sequencer bundle. The optional term input
// exists only when SCG_BURST_TERM_EN is defined.
//
// Handshake: start is a level request the controller holds until it sees done;
// done stays high while start is held and the sequencer returns to idle one
// cycle after start drops. A new request needs start low for at least a cycle.
interface scg_writeap_burst_if
  import scg_pkg::*;
#(
  parameter int BURST_LEN = 4
);
  localparam int BEAT_W = scg_beat_w(BURST_LEN);

  logic              start;
`ifdef SCG_BURST_TERM_EN
  logic              term;
`endif
  logic              done;
  logic              chip;
  cmd_t              command;
  logic [BEAT_W-1:0] beat;
  logic              busy;
  wap_state_e        state;

`ifdef SCG_BURST_TERM_EN
  modport master (output start, term, input done, chip, command, beat, busy, state);
  modport slave  (input start, term, output done, chip, command, beat, busy, state);
`else
  modport master (output start, input done, chip, command, beat, busy, state);
  modport slave  (input start, output done, chip, command, beat, busy, state);
`endif

endinterface

// File: rtl/scg_wait_cnt.sv
// Loadable down-counter with zero flag, shared by the scg_* sequencers for
// their fixed-length timing waits. Load has priority; counting stops at zero.
module scg_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scg_writeap_burst.sv
// Burst write with auto-precharge: WRITEA, BURST_LEN data beats, tWR, tRP, done.
// Define SCG_BURST_TERM_EN to allow early burst termination through bus.term.
module scg_writeap_burst
  import scg_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int TWR       = 2,
  parameter int TRP       = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  scg_writeap_burst_if.slave    bus
);

  localparam int BEAT_W = scg_beat_w(BURST_LEN);
  localparam int CNT_W  = $clog2(scg_max(TWR, TRP) + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  TWR_LOAD  = CNT_W'(TWR - 1);
  localparam logic [CNT_W-1:0]  TRP_LOAD  = CNT_W'(TRP - 1);

  wap_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              term_w;

`ifdef SCG_BURST_TERM_EN
  assign term_w = bus.term;
`else
  assign term_w = 1'b0;
`endif

  scg_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      WAP_IDLE: begin
        if (bus.start) begin
          state_d = WAP_WRITE;
          beat_d  = '0;
        end
      end
      WAP_WRITE: begin
        // The WRITEA cycle already carries beat 0.
        if ((BURST_LEN == 1) || term_w) begin
          state_d  = WAP_RECOVER;
          beat_d   = '0;
          cnt_load = 1'b1;
          cnt_val  = TWR_LOAD;
        end else begin
          state_d = WAP_BURST;
          beat_d  = BEAT_W'(1);
        end
      end
      WAP_BURST: begin
        if ((beat_q == LAST_BEAT) || term_w) begin
          state_d  = WAP_RECOVER;
          beat_d   = '0;
          cnt_load = 1'b1;
          cnt_val  = TWR_LOAD;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WAP_RECOVER: begin
        if (cnt_zero) begin
          state_d  = WAP_PRECHG;
          cnt_load = 1'b1;
          cnt_val  = TRP_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAP_PRECHG: begin
        if (cnt_zero) begin
          state_d = WAP_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAP_DONE: begin
        // No re-trigger: start must drop before another sequence can begin.
        if (!bus.start) begin
          state_d = WAP_IDLE;
        end
      end
      default: begin
        state_d = WAP_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= WAP_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs decode registered state only, so start never reaches them combinationally.
  assign bus.done    = (state_q == WAP_DONE);
  assign bus.chip    = (state_q == WAP_WRITE) || (state_q == WAP_BURST);
  assign bus.command = (state_q == WAP_WRITE) ? CMD_WRITEA : CMD_NOP;
  assign bus.beat    = beat_q;
  assign bus.busy    = (state_q != WAP_IDLE) && (state_q != WAP_DONE);
  assign bus.state   = state_q;

endmodule

// File: tb/tb_scg_writeap_burst.sv
// Bench for scg_writeap_burst: a default instance and a single-beat instance
// checked every cycle against a cycle-offset model of the command sequence.
module tb_scg_writeap_burst;
  import scg_pkg::*;

  localparam int A_BL = 4, A_TWR = 2, A_TRP = 2;
  localparam int B_BL = 1, B_TWR = 1, B_TRP = 1;

  logic clk;
  logic n_rst;
  bit   term_v;

  int n_checks;
  int n_fail;

  // Model: pos = cycles since the WRITEA cycle (-1 when idle), ebl = beats
  // this sequence will actually carry.
  int pos_a, ebl_a, pos_b, ebl_b;

  scg_writeap_burst_if #(.BURST_LEN(A_BL)) bus_a ();
  scg_writeap_burst_if #(.BURST_LEN(B_BL)) bus_b ();

  scg_writeap_burst #(.BURST_LEN(A_BL), .TWR(A_TWR), .TRP(A_TRP)) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_a.slave)
  );

  scg_writeap_burst #(.BURST_LEN(B_BL), .TWR(B_TWR), .TRP(B_TRP)) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_adv(inout int pos, inout int ebl, input int bl, input int twr,
                           input int trp, input bit s, input bit t, input bit rst_ok);
    if (!rst_ok) begin
      pos = -1;
      ebl = bl;
    end else if (pos < 0) begin
      if (s) begin
        pos = 0;
        ebl = bl;
      end
    end else if (pos < ebl + twr + trp) begin
      if (t && (pos < ebl)) ebl = pos + 1;
      pos++;
    end else if (!s) begin
      pos = -1;
    end
  endtask

  task automatic check_one(input string name, input int pos, input int ebl, input int total,
                           input logic done, input logic chip, input cmd_t cmd,
                           input logic [31:0] beat, input logic busy);
    int e_done, e_chip, e_cmd, e_beat, e_busy;
    e_done = 0; e_chip = 0; e_cmd = 0; e_beat = 0; e_busy = 0;
    if (pos >= 0 && pos < ebl) begin
      e_chip = 1;
      e_beat = pos;
      e_cmd  = (pos == 0) ? 5 : 0;
      e_busy = 1;
    end else if (pos >= 0 && pos < total) begin
      e_busy = 1;
    end else if (pos >= total) begin
      e_done = 1;
    end
    chk({name, "_done"},    32'(done), e_done);
    chk({name, "_chip"},    32'(chip), e_chip);
    chk({name, "_command"}, 32'(cmd),  e_cmd);
    chk({name, "_beat"},    beat,      e_beat);
    chk({name, "_busy"},    32'(busy), e_busy);
  endtask

  task automatic check_all();
    check_one("a", pos_a, ebl_a, ebl_a + A_TWR + A_TRP, bus_a.done, bus_a.chip,
              bus_a.command, 32'(bus_a.beat), bus_a.busy);
    check_one("b", pos_b, ebl_b, ebl_b + B_TWR + B_TRP, bus_b.done, bus_b.chip,
              bus_b.command, 32'(bus_b.beat), bus_b.busy);
  endtask

  // Called just after a falling edge: drive inputs, advance the model across
  // the next rising edge, then check at the following falling edge.
  task automatic step(input bit s, input bit t);
    bus_a.start = s;
    bus_b.start = s;
    term_v      = t;
    model_adv(pos_a, ebl_a, A_BL, A_TWR, A_TRP, s, t, n_rst);
    model_adv(pos_b, ebl_b, B_BL, B_TWR, B_TRP, s, t, n_rst);
    @(negedge clk);
    check_all();
  endtask

`ifdef SCG_BURST_TERM_EN
  assign bus_a.term = term_v;
  assign bus_b.term = term_v;
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    term_v   = 1'b0;
    pos_a = -1; ebl_a = A_BL;
    pos_b = -1; ebl_b = B_BL;
    n_rst       = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;

    // Reset values
    @(negedge clk);
    check_all();
    step(0, 0);
    n_rst = 1'b1;
    step(0, 0);

    // Start held from edge 0 through done, then dropped
    repeat (12) step(1, 0);
    repeat (2) step(0, 0);

    // Start dropped mid-burst: sequence still completes
    repeat (3) step(1, 0);
    repeat (10) step(0, 0);

    // Asynchronous reset during beat 2 of the default burst
    step(1, 0);
    step(0, 0);
    step(0, 0);
    chk("pre_reset_beat", 32'(bus_a.beat), 32'd2);
    #1 n_rst = 1'b0;
    #1;
    pos_a = -1; ebl_a = A_BL;
    pos_b = -1; ebl_b = B_BL;
    chk("rst_chip",    32'(bus_a.chip),    32'd0);
    chk("rst_command", 32'(bus_a.command), 32'd0);
    chk("rst_busy",    32'(bus_a.busy),    32'd0);
    chk("rst_beat",    32'(bus_a.beat),    32'd0);
    @(negedge clk);
    step(0, 0);
    n_rst = 1'b1;
    repeat (3) step(0, 0);

    // Start held through DONE, then drop and reassert once
    repeat (14) step(1, 0);
    step(0, 0);
    repeat (12) step(1, 0);
    repeat (2) step(0, 0);

`ifdef SCG_BURST_TERM_EN
    // Terminate the default burst during its second beat
    step(1, 0);
    step(0, 0);
    step(0, 1);
    repeat (8) step(0, 0);
`endif

    // Randomised start levels (and terminations when available)
    for (int i = 0; i < 400; i++) begin
      bit s, t;
      s = ($urandom_range(0, 9) < 6);
      t = 1'b0;
`ifdef SCG_BURST_TERM_EN
      t = ($urandom_range(0, 7) == 0);
`endif
      step(s, t);
    end
    repeat (12) step(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scg_writeap_burst.md
Name: scg_writeap_burst

Overview:
Parametrised burst-write-with-auto-precharge command sequence generator, the next generation of the single-beat write-AP sequencer.
- Started by the SDRAM controller's main FSM; generates the WRITEA command, drives data-beat strobes for BURST_LEN beats, then times write recovery (tWR) and precharge (tRP) before reporting done.
- Sits beside the other scg_* sequencers under the controller top and shares their start/done handshake.

Parameters:
BURST_LEN, 4, data beats per write burst (1..8; 1 reproduces single-write behaviour plus timing waits)
TWR, 2, write-recovery cycles after last beat (>=1)
TRP, 2, precharge cycles after recovery (>=1)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  level request from controller FSM; held until done seen
done  out  1  sequence complete; high in DONE state only
chip  out  1  DQ output enable / data-beat strobe; high on every data beat
command  out  4  SDRAM command code from scg_pkg (CMD_NOP or CMD_WRITEA)
beat  out  $clog2(BURST_LEN) (min 1)  index of current data beat, 0..BURST_LEN-1
busy  out  1  high in any state other than IDLE and DONE

Behaviour:
- Reset (async, n_rst low): state=IDLE, all counters 0. Outputs: done=0, chip=0, command=CMD_NOP, beat=0, busy=0. Reset mid-sequence aborts immediately with no further commands.
- States: IDLE, WRITE, BURST, RECOVER, PRECHG, DONE.
- IDLE: start=1 -> WRITE; otherwise stay.
- WRITE (1 cycle): command=CMD_WRITEA, chip=1, beat=0.
  - BURST_LEN==1 -> RECOVER.
  - else -> BURST.
- BURST: chip=1, command=CMD_NOP, beat increments each cycle 1..BURST_LEN-1. -> RECOVER after beat BURST_LEN-1.
- RECOVER: chip=0, exactly TWR cycles, then -> PRECHG.
- PRECHG: exactly TRP cycles, then -> DONE.
- DONE: done=1, command=CMD_NOP. Stay while start=1; start=0 -> IDLE.
  - A new sequence needs start to be low for at least one cycle. No re-trigger from DONE.
- start dropping mid-sequence is ignored; the sequence always completes.
- Latency: start sampled high at edge 0 gives WRITE in cycle 1 and done first high in cycle 1+BURST_LEN+TWR+TRP (9 with defaults).
- beat resets to 0 on entering WRITE and holds 0 outside WRITE/BURST.
- Wait counter: loads TWR-1 on entering RECOVER and TRP-1 on entering PRECHG; decrements to 0. Width is $clog2(max(TWR,TRP)+1).
- All outputs are decoded from registered state and counters; no combinational path from start to outputs.

Optional Feature:
Macro SCG_BURST_TERM_EN.
- With macro: adds input `term` (1 bit). term=1 in WRITE or BURST ends data beats after the current beat (chip drops next cycle) and moves to RECOVER. Full TWR and TRP still elapse. term is ignored in other states.
- Without macro: no term port; the burst always runs BURST_LEN beats.

Decomposition:
- scg_pkg holds:
  - the 4-bit command typedef/constants (CMD_NOP=4'd0, CMD_WRITEA=4'd5), shared by all scg_* blocks;
  - the state enum for this block.
- One sub-module: scg_wait_cnt, a loadable down-counter with zero flag. It is reused for the RECOVER and PRECHG waits and by sibling read/refresh sequencers.

Test Plan:
1. Defaults; reset; pulse-hold start from cycle 0 -> command=5 and chip=1 in cycle 1; chip=1 cycles 1-4 with beat 0,1,2,3; done=1 from cycle 9 while start held; start low -> IDLE next cycle, done=0.
2. BURST_LEN=1, TWR=1, TRP=1 -> WRITE cycle 1 (chip=1, beat=0), done at cycle 4; no BURST state visited.
3. start dropped in cycle 3 of a default burst -> sequence unchanged, done at cycle 9, then IDLE next cycle.
4. n_rst asserted in cycle 3 (BURST, beat=2) -> same instant chip=0, command=0, busy=0; after release, IDLE until the next start.
5. start held high through DONE for 5 cycles -> done stays 1, no second WRITEA; drop and reassert -> exactly one new WRITEA.
6. SCG_BURST_TERM_EN, defaults, term=1 in cycle 2 -> chip high cycles 1-2 only (beats 0,1), RECOVER cycles 3-4, PRECHG 5-6, done at cycle 7.
